// File: rtl/l1_dcache_pkg.sv
// Shared types and FSM encodings for the direct-mapped, write-back L1 data cache.
package l1_dcache_pkg;

    localparam int ADDR_BITS = 12;
    localparam int DEF_SET_BITS = 3;
    localparam int DEF_LINE_BITS = 128;

    typedef logic [DEF_SET_BITS-1:0]           lc3b_cache_idx;
    typedef logic [ADDR_BITS-DEF_SET_BITS-1:0] lc3b_cache_tag;
    typedef logic [DEF_LINE_BITS/8-1:0]        lc3b_line_mask;
    typedef logic [1:0]                        lc3b_dcache_state;

    localparam lc3b_dcache_state COMPARE   = 2'd0;
    localparam lc3b_dcache_state WRITEBACK = 2'd1;
    localparam lc3b_dcache_state ALLOCATE  = 2'd2;

endpackage

// File: rtl/l1_dcache_array.sv
// Valid/dirty/tag/data storage: combinational read, byte-masked CPU write, full-line fill.
module dcache_array
    import l1_dcache_pkg::*;
#(
    parameter int SET_BITS  = DEF_SET_BITS,
    parameter int LINE_BITS = DEF_LINE_BITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SET_BITS-1:0]           idx,
    input  logic                          wr_en,
    input  logic [LINE_BITS/8-1:0]        wr_sel,
    input  logic [LINE_BITS-1:0]          wr_data,
    input  logic                          load_en,
    input  logic [ADDR_BITS-SET_BITS-1:0] load_tag,
    input  logic [LINE_BITS-1:0]          load_data,
    output logic                          valid,
    output logic                          dirty,
    output logic [ADDR_BITS-SET_BITS-1:0] tag,
    output logic [LINE_BITS-1:0]          data
);

    localparam int SETS = 1 << SET_BITS;

    logic [SETS-1:0]                 valid_q;
    logic [SETS-1:0]                 dirty_q;
    logic [ADDR_BITS-SET_BITS-1:0]   tag_mem  [SETS];
    logic [LINE_BITS-1:0]            data_mem [SETS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (load_en) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (wr_en) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays carry no reset; valid bits gate their use, so they map onto plain RAM.
    always_ff @(posedge clk) begin
        if (load_en) begin
            tag_mem[idx]  <= load_tag;
            data_mem[idx] <= load_data;
        end else if (wr_en) begin
            for (int i = 0; i < LINE_BITS/8; i++) begin
                if (wr_sel[i]) data_mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign valid = valid_q[idx];
    assign dirty = dirty_q[idx];
    assign tag   = tag_mem[idx];
    assign data  = data_mem[idx];

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped write-back/write-allocate L1 D-cache with COMPARE/WRITEBACK/ALLOCATE control.
module l1_dcache
    import l1_dcache_pkg::*;
#(
    parameter int SET_BITS  = DEF_SET_BITS,
    parameter int LINE_BITS = DEF_LINE_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_BITS-1:0]   mem_address,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [LINE_BITS-1:0]   mem_wdata,
    input  logic [LINE_BITS/8-1:0] mem_sel,
    output logic [LINE_BITS-1:0]   mem_rdata,
    output logic                   mem_resp,
    output logic [ADDR_BITS-1:0]   pmem_address,
    output logic                   pmem_read,
    output logic                   pmem_write,
    output logic [LINE_BITS-1:0]   pmem_wdata,
    input  logic [LINE_BITS-1:0]   pmem_rdata,
    input  logic                   pmem_resp
);

    logic [SET_BITS-1:0]           idx;
    logic [ADDR_BITS-SET_BITS-1:0] req_tag;
    logic                          line_valid;
    logic                          line_dirty;
    logic [ADDR_BITS-SET_BITS-1:0] line_tag;
    logic [LINE_BITS-1:0]          line_data;
    logic                          hit;
    logic                          wr_en;
    logic                          load_en;
    lc3b_dcache_state              state;
    lc3b_dcache_state              next_state;

    assign idx     = mem_address[SET_BITS-1:0];
    assign req_tag = mem_address[ADDR_BITS-1:SET_BITS];
    assign hit     = line_valid && (line_tag == req_tag);

    dcache_array #(.SET_BITS(SET_BITS), .LINE_BITS(LINE_BITS)) u_array (
        .clk       (clk),
        .rst       (rst),
        .idx       (idx),
        .wr_en     (wr_en),
        .wr_sel    (mem_sel),
        .wr_data   (mem_wdata),
        .load_en   (load_en),
        .load_tag  (req_tag),
        .load_data (pmem_rdata),
        .valid     (line_valid),
        .dirty     (line_dirty),
        .tag       (line_tag),
        .data      (line_data)
    );

    // NOTE: state is sequential, so it takes non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= COMPARE;
        else     state <= next_state;
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        next_state   = state;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        wr_en        = 1'b0;
        load_en      = 1'b0;
        case (state)
            COMPARE: begin
                if (mem_read || mem_write) begin
                    if (hit) begin
                        mem_resp  = 1'b1;
                        mem_rdata = line_data;
                        wr_en     = mem_write;
                    end else begin
                        next_state = line_dirty ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {line_tag, idx};
                pmem_wdata   = line_data;
                if (pmem_resp) next_state = ALLOCATE;
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = mem_address;
                if (pmem_resp) begin
                    load_en    = 1'b1;
                    next_state = COMPARE;
                end
            end
            default: next_state = COMPARE;
        endcase
    end

endmodule

// File: tb/tb_l1_dcache.sv
// Directed bench for l1_dcache: fills, hits, byte-masked writes, dirty eviction and reset mid-miss.
module tb_l1_dcache;

    localparam int LAT = 3;
    localparam logic [127:0] L1 = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    localparam logic [127:0] M1 = 128'h0011_2233_4455_6677_8899_AABB_CCDD_BEEF;
    localparam logic [127:0] L2 = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
    localparam logic [127:0] WB = 128'h5555_5555_5555_5555_5555_5555_5555_BEEF;
    localparam logic [127:0] W  = 128'hCAFE_F00D_1234_5678_9ABC_DEF0_0F0F_F0F0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [11:0]  mem_address = '0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [127:0] mem_wdata = '0;
    logic [15:0]  mem_sel = '0;
    logic [127:0] mem_rdata;
    logic         mem_resp;
    logic [11:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [127:0] mem [4096];
    logic         resp_en = 1'b1;
    int           cnt = 0;
    int           rd_count = 0;
    int           wr_count = 0;
    logic [11:0]  last_rd_addr = '0;
    logic [11:0]  last_wr_addr = '0;
    logic [127:0] last_wr_data = '0;

    l1_dcache dut (
        .clk          (clk),
        .rst          (rst),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_sel      (mem_sel),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    // Physical memory: answers a held strobe after LAT falling edges with a one-cycle pmem_resp.
    always @(negedge clk) begin
        if (pmem_resp) begin
            pmem_resp = 1'b0;
            cnt = 0;
        end else if (rst || !resp_en) begin
            cnt = 0;
        end else if (pmem_read || pmem_write) begin
            cnt++;
            if (cnt == LAT) begin
                pmem_resp = 1'b1;
                if (pmem_write) begin
                    mem[pmem_address] = pmem_wdata;
                    wr_count++;
                    last_wr_addr = pmem_address;
                    last_wr_data = pmem_wdata;
                end else begin
                    pmem_rdata = mem[pmem_address];
                    rd_count++;
                    last_rd_addr = pmem_address;
                end
            end
        end
    end

    task automatic do_req(input logic rd, input logic wr, input logic [11:0] addr,
                          input logic [15:0] sel, input logic [127:0] wd,
                          output logic ok, output logic [127:0] rdata, output int cycles);
        @(negedge clk);
        mem_address = addr;
        mem_read    = rd;
        mem_write   = wr;
        mem_sel     = sel;
        mem_wdata   = wd;
        ok = 1'b0;
        rdata = '0;
        cycles = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (mem_resp) begin
                ok = 1'b1;
                rdata = mem_rdata;
                break;
            end
            cycles++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        checks++; if (mem_resp !== 1'b0) begin failures++; $display("FAIL reset_mem_resp got=%b exp=0", mem_resp); end
        checks++; if (pmem_read !== 1'b0) begin failures++; $display("FAIL reset_pmem_read got=%b exp=0", pmem_read); end
        checks++; if (pmem_write !== 1'b0) begin failures++; $display("FAIL reset_pmem_write got=%b exp=0", pmem_write); end
        checks++; if (pmem_address !== 12'h000) begin failures++; $display("FAIL reset_pmem_address got=%h exp=000", pmem_address); end
        checks++; if (pmem_wdata !== 128'h0) begin failures++; $display("FAIL reset_pmem_wdata got=%h exp=0", pmem_wdata); end
        checks++; if (mem_rdata !== 128'h0) begin failures++; $display("FAIL reset_mem_rdata got=%h exp=0", mem_rdata); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_clean_miss;
        logic ok; logic [127:0] rd; int cyc;
        do_req(1'b1, 1'b0, 12'h0A3, 16'h0, '0, ok, rd, cyc);
        checks++; if (!ok || cyc == 0) begin failures++; $display("FAIL clean_miss_resp ok=%b cycles=%0d exp ok=1 cycles>0", ok, cyc); end
        checks++; if (rd !== L1) begin failures++; $display("FAIL clean_miss_rdata got=%h exp=%h", rd, L1); end
        checks++; if (last_rd_addr !== 12'h0A3 || rd_count != 1) begin failures++; $display("FAIL clean_miss_pmem_read addr=%h n=%0d exp 0a3 n=1", last_rd_addr, rd_count); end
        checks++; if (wr_count != 0) begin failures++; $display("FAIL clean_miss_no_write got=%0d exp=0", wr_count); end
    endtask

    task automatic test_hit;
        logic ok; logic [127:0] rd; int cyc;
        do_req(1'b1, 1'b0, 12'h0A3, 16'h0, '0, ok, rd, cyc);
        checks++; if (!ok || cyc != 0) begin failures++; $display("FAIL hit_latency ok=%b cycles=%0d exp ok=1 cycles=0", ok, cyc); end
        checks++; if (rd !== L1) begin failures++; $display("FAIL hit_rdata got=%h exp=%h", rd, L1); end
        checks++; if (rd_count != 1) begin failures++; $display("FAIL hit_no_pmem_read got=%0d exp=1", rd_count); end
    endtask

    task automatic test_write_hit;
        logic ok; logic [127:0] rd; int cyc;
        do_req(1'b0, 1'b1, 12'h0A3, 16'h0003, WB, ok, rd, cyc);
        checks++; if (!ok || cyc != 0) begin failures++; $display("FAIL write_hit_latency ok=%b cycles=%0d exp ok=1 cycles=0", ok, cyc); end
        do_req(1'b1, 1'b0, 12'h0A3, 16'h0, '0, ok, rd, cyc);
        checks++; if (rd !== M1) begin failures++; $display("FAIL write_hit_merge got=%h exp=%h", rd, M1); end
    endtask

    task automatic test_dirty_evict;
        logic ok; logic [127:0] rd; int cyc;
        do_req(1'b1, 1'b0, 12'h1A3, 16'h0, '0, ok, rd, cyc);
        checks++; if (wr_count != 1 || last_wr_addr !== 12'h0A3) begin failures++; $display("FAIL evict_wb_addr n=%0d addr=%h exp n=1 addr=0a3", wr_count, last_wr_addr); end
        checks++; if (last_wr_data !== M1) begin failures++; $display("FAIL evict_wb_data got=%h exp=%h", last_wr_data, M1); end
        checks++; if (last_rd_addr !== 12'h1A3) begin failures++; $display("FAIL evict_fill_addr got=%h exp=1a3", last_rd_addr); end
        checks++; if (rd !== L2) begin failures++; $display("FAIL evict_rdata got=%h exp=%h", rd, L2); end
        do_req(1'b1, 1'b0, 12'h0A3, 16'h0, '0, ok, rd, cyc);
        checks++; if (wr_count != 1) begin failures++; $display("FAIL evict_clean_after_fill wr=%0d exp=1", wr_count); end
        checks++; if (rd !== M1) begin failures++; $display("FAIL evict_refetch got=%h exp=%h", rd, M1); end
    endtask

    task automatic test_reset_mid_miss;
        logic ok; logic [127:0] rd; int cyc; int seen;
        int rd_before;
        resp_en = 1'b0;
        @(negedge clk);
        mem_address = 12'h1A3;
        mem_read = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (pmem_read) begin seen = 1; break; end
        end
        checks++; if (seen != 1) begin failures++; $display("FAIL rst_mid_allocate_reached got=%0d exp=1", seen); end
        #1 rst = 1'b1;
        #1;
        checks++; if (pmem_read !== 1'b0) begin failures++; $display("FAIL rst_mid_pmem_read got=%b exp=0", pmem_read); end
        checks++; if (pmem_address !== 12'h000) begin failures++; $display("FAIL rst_mid_pmem_address got=%h exp=000", pmem_address); end
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        resp_en = 1'b1;
        rd_before = rd_count;
        do_req(1'b1, 1'b0, 12'h1A3, 16'h0, '0, ok, rd, cyc);
        checks++; if (rd_count != rd_before + 1 || cyc == 0) begin failures++; $display("FAIL rst_mid_remiss reads=%0d cycles=%0d exp reads=%0d cycles>0", rd_count, cyc, rd_before + 1); end
        checks++; if (rd !== L2) begin failures++; $display("FAIL rst_mid_rdata got=%h exp=%h", rd, L2); end
    endtask

    task automatic test_sel_zero;
        logic ok; logic [127:0] rd; int cyc; int wr_before;
        do_req(1'b0, 1'b1, 12'h1A3, 16'h0000, W, ok, rd, cyc);
        checks++; if (!ok || cyc != 0) begin failures++; $display("FAIL sel0_resp ok=%b cycles=%0d exp ok=1 cycles=0", ok, cyc); end
        do_req(1'b1, 1'b0, 12'h1A3, 16'h0, '0, ok, rd, cyc);
        checks++; if (rd !== L2) begin failures++; $display("FAIL sel0_data got=%h exp=%h", rd, L2); end
        wr_before = wr_count;
        do_req(1'b1, 1'b0, 12'h0A3, 16'h0, '0, ok, rd, cyc);
        checks++; if (wr_count != wr_before + 1) begin failures++; $display("FAIL sel0_dirty_wb n=%0d exp=%0d", wr_count, wr_before + 1); end
        checks++; if (last_wr_addr !== 12'h1A3 || last_wr_data !== L2) begin failures++; $display("FAIL sel0_wb_line addr=%h data=%h exp 1a3 %h", last_wr_addr, last_wr_data, L2); end
    endtask

    task automatic test_read_write_both;
        logic ok; logic [127:0] rd; int cyc; int wr_before;
        do_req(1'b1, 1'b1, 12'h0A3, 16'hFFFF, W, ok, rd, cyc);
        checks++; if (!ok || cyc != 0 || rd !== M1) begin failures++; $display("FAIL rw_pre_line ok=%b cycles=%0d got=%h exp=%h", ok, cyc, rd, M1); end
        do_req(1'b1, 1'b0, 12'h0A3, 16'h0, '0, ok, rd, cyc);
        checks++; if (rd !== W) begin failures++; $display("FAIL rw_replaced got=%h exp=%h", rd, W); end
        wr_before = wr_count;
        do_req(1'b1, 1'b0, 12'h1A3, 16'h0, '0, ok, rd, cyc);
        checks++; if (wr_count != wr_before + 1 || last_wr_addr !== 12'h0A3 || last_wr_data !== W) begin failures++; $display("FAIL rw_dirty_wb n=%0d addr=%h data=%h exp n=%0d 0a3 %h", wr_count, last_wr_addr, last_wr_data, wr_before + 1, W); end
        checks++; if (rd !== L2) begin failures++; $display("FAIL rw_refill got=%h exp=%h", rd, L2); end
    endtask

    initial begin
        mem[12'h0A3] = L1;
        mem[12'h1A3] = L2;
        test_reset();
        test_clean_miss();
        test_hit();
        test_write_hit();
        test_dirty_evict();
        test_reset_mid_miss();
        test_sel_zero();
        test_read_write_both();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l1_dcache.md
Name: l1_dcache

Overview:
Direct-mapped, write-back, write-allocate L1 data cache sitting directly downstream of the pipeline's MEM-stage memory port. It consumes the line-granular requests the pipeline issues (12-bit line address, 128-bit line, 16-bit byte-select mask) and serves them from a local array. It forwards misses and dirty evictions to the physical-memory side over a single-outstanding read/write/resp handshake.

Parameters:
SET_BITS, 3, log2 of the number of sets (default 8 lines); index = mem_address[SET_BITS-1:0], tag = mem_address[11:SET_BITS]
LINE_BITS, 128, line width in bits; byte mask width = LINE_BITS/8

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
mem_address  in  12  CPU line address (lc3b_wb_adr)
mem_read  in  1  CPU read request, held until mem_resp
mem_write  in  1  CPU write request, held until mem_resp
mem_wdata  in  128  CPU write line (lc3b_c_line)
mem_sel  in  16  byte enables for mem_wdata; bit i covers bits [8i+7:8i]
mem_rdata  out  128  line returned to CPU (lc3b_line)
mem_resp  out  1  one-cycle completion pulse
pmem_address  out  12  physical line address
pmem_read  out  1  physical read strobe
pmem_write  out  1  physical write strobe
pmem_wdata  out  128  evicted line
pmem_rdata  in  128  fill line
pmem_resp  in  1  physical completion, one cycle

Behaviour:
- Reset (async, immediate): all valid and dirty bits 0; FSM -> COMPARE; mem_resp, pmem_read, pmem_write = 0; pmem_address, pmem_wdata, mem_rdata = 0. Tag/data arrays are not cleared. Reset mid-miss abandons the transaction; dirty data is lost.
- State COMPARE, no request: all outputs idle.
- State COMPARE, request with hit (valid[idx] && tag[idx]==req tag): mem_resp=1 combinationally in the same cycle; mem_rdata=data[idx]. On a write hit, at the clock edge, bytes with mem_sel[i]=1 take mem_wdata and dirty[idx] is set. The hit latency is therefore 0 extra cycles.
- State COMPARE, miss, victim dirty: go to WRITEBACK. Otherwise go to ALLOCATE. mem_resp=0.
- State WRITEBACK: pmem_write=1, pmem_address={tag[idx],idx}, pmem_wdata=data[idx]. On pmem_resp go to ALLOCATE.
- State ALLOCATE: pmem_read=1, pmem_address=mem_address. On pmem_resp: data[idx]<=pmem_rdata, tag<=req tag, valid<=1, dirty<=0. Then go to COMPARE, which hits on the next cycle.
- Miss latency: clean miss = pmem latency + 1 cycle; dirty miss = 2x pmem latency + 1 cycle.
- pmem strobes stay high and stable until pmem_resp. They drop the cycle after the transition.
- CPU must hold mem_address, mem_read, mem_write, mem_wdata and mem_sel stable until mem_resp. The cache does not latch them.
- If mem_read and mem_write are both 1, the request is treated as a write; mem_rdata still shows the pre-write line.
- mem_sel=0 on a write hit: mem_resp is given and dirty is set; data is unchanged.
- Write miss: the line is allocated first, then merged in COMPARE. A full-line write still fetches.
- Stray pmem_resp in COMPARE is ignored.

Decomposition:
- lc3b_types gains: lc3b_cache_idx (SET_BITS), lc3b_cache_tag (12-SET_BITS), lc3b_line_mask (16 bits), and enum lc3b_dcache_state {COMPARE, WRITEBACK, ALLOCATE}.
- One sub-module, dcache_array: holds valid/dirty/tag/data storage with async clear of valid/dirty. It has combinational read plus byte-masked write, plus a full-line load port.
- The FSM (dcache_control) lives in l1_dcache.

Test Plan:
- After reset, read 12'h0A3 (idx 3, tag 0x14), memory returns line L1 after 3 cycles -> pmem_read with pmem_address=12'h0A3; after fill, mem_resp=1 with mem_rdata=L1; no pmem_write.
- Repeat read of 12'h0A3 -> mem_resp=1 in the same cycle as the request; pmem_read stays 0.
- Write 12'h0A3 with mem_sel=16'h0003, wdata low half 16'hBEEF -> mem_resp in the same cycle; a subsequent read returns L1 with bits [15:0]=16'hBEEF and the other bytes unchanged.
- Read 12'h1A3 (same idx, tag 0x34) -> pmem_write to 12'h0A3 carrying the merged line, then pmem_read of 12'h1A3, then mem_resp with the new line; the dirty bit for idx 3 is 0.
- Assert rst while in ALLOCATE with pmem_read=1 -> pmem_read=0 immediately (no clock); re-read of 12'h1A3 misses again.
- Simultaneous mem_read=mem_write=1 on a hit with mem_sel=16'hFFFF -> mem_resp=1; the line is replaced by mem_wdata and dirty=1.
